// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the MIPS control path and the multiply/divide unit.
// Latency: none, this is wiring only.
// Backpressure: the requester holds off new starts while busy is high.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divByZero;

    // Requester side: drives the operation, observes status and results.
    modport master (
        output start, op, operandA, operandB,
        input  busy, done, hi, lo, divByZero
    );

    // Unit side: samples the operation, drives status and results.
    modport slave (
        input  start, op, operandA, operandB,
        output busy, done, hi, lo, divByZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU producing HI/LO for the MIPS datapath.
// Latency: WIDTH+1 cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          resetN,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 last_iter;

    logic [CW-1:0]        iter_cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 is_div;
    logic                 neg_main;
    logic                 neg_rem;
    logic                 b_zero;

    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       mul_add;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_step;

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state decode: accept in IDLE, count WIDTH iterations, one FIX cycle.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_iter = (iter_cnt == LAST_ITER);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN:     if (last_iter) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Signed ops work on magnitudes; the most-negative value maps to itself as unsigned.
    always_comb begin
        a_neg = bus.op[0] & bus.operandA[WIDTH-1];
        b_neg = bus.op[0] & bus.operandB[WIDTH-1];
        a_mag = a_neg ? -bus.operandA : bus.operandA;
        b_mag = b_neg ? -bus.operandB : bus.operandB;
    end

    // One shift-add or restoring-subtract step on the accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_add   = acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When div_ge holds the true difference is below opnd, so WIDTH bits are exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div)
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_step = {mul_add, acc[WIDTH-1:1]};
    end

    // Sign correction and divide-by-zero override applied in the FIX cycle.
    always_comb begin
        prod = neg_main ? -acc : acc;
        quo  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (b_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            iter_cnt <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            iter_cnt <= '0;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            opnd     <= bus.op[1] ? b_mag : a_mag;
            a_raw    <= bus.operandA;
            is_div   <= bus.op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= bus.op[1] & a_neg;
            b_zero   <= bus.op[1] & (bus.operandB == '0);
        end else if (state == RUN) begin
            acc      <= acc_step;
            iter_cnt <= iter_cnt + CW'(1);
        end else if (state == FIX) begin
            iter_cnt <= '0;
            hi_q     <= fix_hi;
            lo_q     <= fix_lo;
            dbz_q    <= is_div & b_zero;
        end
    end

    // Registered status: busy follows the next state, done marks the FIX cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == FIX);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.divByZero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit at WIDTH=32 and WIDTH=8.
// Latency: checks done arrives WIDTH+1 cycles after acceptance.
// Backpressure: exercises ignored mid-run starts and starts in the done cycle.
module tb_mult_div_unit;
    logic clk;
    logic resetN;

    int n_checks = 0;
    int n_pass   = 0;

    mult_div_unit_if #(.WIDTH(32)) b32 ();
    mult_div_unit_if #(.WIDTH(8))  b8 ();

    mult_div_unit #(.WIDTH(32)) dut32 (.clock(clk), .resetN(resetN), .bus(b32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clock(clk), .resetN(resetN), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on sign-extended 64-bit values.
    function automatic void model(input int w, input logic [1:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned hi, output longint unsigned lo,
                                  output longint unsigned dbz);
        longint unsigned mask;
        longint unsigned p;
        longint          sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        dbz = 0;
        if (op[1] == 1'b0) begin
            p  = op[0] ? longint'(sa * sb) : a * b;
            lo = p & mask;
            hi = (p >> w) & mask;
        end else if (b == 0) begin
            dbz = 1;
            lo  = mask;
            hi  = a;
        end else if (op[0] == 1'b0) begin
            lo = a / b;
            hi = a % b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = longint'(q) & mask;
            hi = longint'(r) & mask;
        end
    endfunction

    task automatic set_in(input int w, input logic s, input logic [1:0] op,
                          input longint unsigned a, input longint unsigned b);
        if (w == 8) begin
            b8.start = s; b8.op = op; b8.operandA = a[7:0]; b8.operandB = b[7:0];
        end else begin
            b32.start = s; b32.op = op; b32.operandA = a[31:0]; b32.operandB = b[31:0];
        end
    endtask

    function automatic longint unsigned get_hi(input int w);
        return (w == 8) ? 64'(b8.hi) : 64'(b32.hi);
    endfunction
    function automatic longint unsigned get_lo(input int w);
        return (w == 8) ? 64'(b8.lo) : 64'(b32.lo);
    endfunction
    function automatic longint unsigned get_busy(input int w);
        return (w == 8) ? 64'(b8.busy) : 64'(b32.busy);
    endfunction
    function automatic longint unsigned get_done(input int w);
        return (w == 8) ? 64'(b8.done) : 64'(b32.done);
    endfunction
    function automatic longint unsigned get_dbz(input int w);
        return (w == 8) ? 64'(b8.divByZero) : 64'(b32.divByZero);
    endfunction

    function automatic longint unsigned rand_val(input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return mask;
            3:       return 64'd1 << (w - 1);
            default: return 64'($urandom) & mask;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge,
    // with operands already scrambled so late changes would show up.
    task automatic issue(input int w, input logic [1:0] op,
                         input longint unsigned a, input longint unsigned b);
        set_in(w, 1'b1, op, a, b);
        @(negedge clk);
        set_in(w, 1'b0, 2'($urandom), 64'($urandom), 64'($urandom));
    endtask

    // Waits for done (bounded), checking latency, busy and results; returns in the done cycle.
    task automatic finish_op(input int w, input logic [1:0] op,
                             input longint unsigned a, input longint unsigned b,
                             input string tag, input int poke_at);
        longint unsigned eh, el, ed;
        int lat;
        bit busy_ok;
        model(w, op, a, b, eh, el, ed);
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 0; c <= w + 20; c++) begin
            if (c > 0) @(negedge clk);
            if (poke_at > 0 && c == poke_at)
                set_in(w, 1'b1, ~op, ~a, b + 64'd3);
            else if (poke_at > 0 && c == poke_at + 1)
                set_in(w, 1'b0, op, a, b);
            if (get_done(w) == 1) begin
                lat = c;
                break;
            end
            if (get_busy(w) != 1) busy_ok = 1'b0;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(w + 1));
        chk({tag, "_busy_run"}, 64'(busy_ok), 1);
        chk({tag, "_busy_done"}, get_busy(w), 0);
        chk({tag, "_hi"}, get_hi(w), eh);
        chk({tag, "_lo"}, get_lo(w), el);
        chk({tag, "_dbz"}, get_dbz(w), ed);
    endtask

    task automatic pulse_end(input int w, input string tag);
        @(negedge clk);
        chk({tag, "_pulse"}, get_done(w), 0);
    endtask

    task automatic do_op(input int w, input logic [1:0] op,
                         input longint unsigned a, input longint unsigned b, input string tag);
        issue(w, op, a, b);
        finish_op(w, op, a, b, tag, 0);
        pulse_end(w, tag);
    endtask

    initial begin
        bit seen_done;
        int w;
        logic [1:0] rop;
        longint unsigned ra, rb;

        resetN = 1'b0;
        set_in(32, 1'b0, 2'b00, 0, 0);
        set_in(8, 1'b0, 2'b00, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", get_busy(32), 0);
        chk("rst_done", get_done(32), 0);
        chk("rst_hi", get_hi(32), 0);
        chk("rst_lo", get_lo(32), 0);
        chk("rst_dbz", get_dbz(32), 0);
        chk("rst8_busy", get_busy(8), 0);
        resetN = 1'b1;
        @(negedge clk);

        do_op(32, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, "multu_max");
        chk("multu_max_hi_c", get_hi(32), 64'hFFFFFFFE);
        chk("multu_max_lo_c", get_lo(32), 64'h00000001);
        do_op(32, 2'b01, 64'hFFFFFFFD, 7, "mult_m3x7");
        chk("mult_m3x7_lo_c", get_lo(32), 64'hFFFFFFEB);
        do_op(32, 2'b01, 64'h80000000, 64'h80000000, "mult_min2");
        chk("mult_min2_hi_c", get_hi(32), 64'h40000000);
        do_op(32, 2'b11, 64'hFFFFFFF9, 2, "div_m7d2");
        chk("div_m7d2_lo_c", get_lo(32), 64'hFFFFFFFD);
        chk("div_m7d2_hi_c", get_hi(32), 64'hFFFFFFFF);
        do_op(32, 2'b10, 7, 2, "divu_7d2");
        do_op(32, 2'b11, 64'h80000000, 64'hFFFFFFFF, "div_ovf");
        chk("div_ovf_lo_c", get_lo(32), 64'h80000000);
        do_op(32, 2'b10, 100, 0, "divu_by0");
        chk("divu_by0_hi_c", get_hi(32), 64'h64);
        chk("divu_by0_dbz_c", get_dbz(32), 1);
        do_op(32, 2'b00, 2, 3, "multu_2x3");
        do_op(32, 2'b11, 64'hFFFFFF00, 0, "div_by0_neg");

        // Start pulsed mid-run with different operands must be ignored.
        issue(32, 2'b00, 64'h1234, 64'h5678);
        finish_op(32, 2'b00, 64'h1234, 64'h5678, "poke", 5);
        pulse_end(32, "poke");

        // Start in the done cycle is accepted back-to-back.
        issue(32, 2'b11, 1000, 64'hFFFFFFF9);
        finish_op(32, 2'b11, 1000, 64'hFFFFFFF9, "b2b_a", 0);
        issue(32, 2'b00, 64'hDEAD, 64'hBEEF);
        finish_op(32, 2'b00, 64'hDEAD, 64'hBEEF, "b2b_b", 0);
        pulse_end(32, "b2b_b");

        // Reset at iteration 10 aborts the operation with no done.
        issue(32, 2'b00, 64'hFFFF, 64'hFFFF);
        repeat (10) @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("arst_busy", get_busy(32), 0);
        chk("arst_done", get_done(32), 0);
        chk("arst_hi", get_hi(32), 0);
        chk("arst_lo", get_lo(32), 0);
        chk("arst_dbz", get_dbz(32), 0);
        seen_done = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (get_done(32) != 0) seen_done = 1'b1;
        end
        chk("arst_no_done", 64'(seen_done), 0);
        do_op(32, 2'b00, 5, 5, "after_rst");
        chk("after_rst_lo_c", get_lo(32), 25);

        // Narrow instance, signed corner cases.
        do_op(8, 2'b01, 64'h80, 64'hFF, "w8_mult_min");
        chk("w8_mult_min_hi_c", get_hi(8), 64'h00);
        chk("w8_mult_min_lo_c", get_lo(8), 64'h80);
        do_op(8, 2'b11, 64'h80, 64'hFF, "w8_div_ovf");
        do_op(8, 2'b11, 64'hF9, 2, "w8_div_m7d2");
        do_op(8, 2'b01, 64'hFD, 7, "w8_mult_m3x7");
        do_op(8, 2'b10, 64'h64, 0, "w8_divu_by0");

        for (int i = 0; i < 60; i++) begin
            w   = (i % 2 == 0) ? 32 : 8;
            rop = 2'($urandom);
            ra  = rand_val(w);
            rb  = rand_val(w);
            do_op(w, rop, ra, rb, $sformatf("rnd%0d_w%0d_op%0d", i, w, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
